aes_key_expander: RTL and testbench
===================================

Name: aes_key_expander

Overview:
Sequential AES key-schedule engine that sits directly upstream of the Cipher and InverseCipher datapaths.
- Accepts a cipher key of Nk words on a start pulse.
- Generates the expanded schedule one 32-bit word per clock.
- Presents the full round-key array, rounds 0..Nr, as one flat bus, plus a done flag.
- Replaces the combinational expansion with an area-lean iterative unit; the same block serves 128-, 192- and 256-bit keys.

Parameters:
Nk, 4, key length in 32-bit words; legal values 4, 6, 8.
Nr, 10, number of rounds; must be 10, 12, 14 for Nk = 4, 6, 8 respectively.

Ports:
clk    input   1              system clock; rising edge active
rst    input   1              asynchronous, active-high reset
start  input   1              one-cycle request to expand key; sampled only in IDLE or DONE
key    input   Nk*32          cipher key; word 0 in the MSBs (FIPS-197 byte order)
busy   output  1              high while expansion is in progress
done   output  1              high while k_sch holds a complete, valid schedule
k_sch  output  (Nr+1)*128     round keys; round 0 in the top 128 bits, round Nr in the bottom 128 bits

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state IDLE, busy=0, done=0, k_sch all zero, word counter and Rcon cleared.
- Reset asserted mid-expansion aborts immediately; no partial schedule is flagged done.
- States: IDLE, EXPAND, DONE.
- IDLE, start=1 at an edge:
  - Load key words into w[0..Nk-1].
  - Set i=Nk, phase counter j=0 (i mod Nk, tracked without a divider), rcon=8'h01.
  - Go to EXPAND with busy=1.
- EXPAND, each edge: compute and store w[i] = w[i-Nk] ^ temp, where temp is:
  - if j==0: SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; then rcon <= xtime(rcon);
  - else if Nk==8 and j==4: SubWord(w[i-1]);
  - else: w[i-1].
  - Then i<=i+1 and j<=(j==Nk-1)?0:j+1.
- Rcon rule: xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00). So 8'h80 is followed by 8'h1b.
- EXPAND exit: when i == 4*(Nr+1)-1 is written, go to DONE; busy=0 and done=1 from that edge.
- Latency: done rises exactly 4*(Nr+1)-Nk edges after the start-sampling edge, i.e. 40 / 46 / 52 cycles for Nk = 4 / 6 / 8.
- k_sch visibility: during EXPAND, k_sch words already written are visible. Consumers use it only while done=1.
- DONE: done and k_sch hold indefinitely.
- start in DONE restarts as from IDLE; done falls on that same edge.
- start during EXPAND is ignored. key is sampled only on the start edge, so key changes at any other time have no effect.
- Storage: word array of 4*(Nr+1) x 32 flops, mapped directly onto k_sch. Word k occupies bits [(4*(Nr+1)-k)*32-1 -: 32].
- SubWord is a byte-wise S-box, 4 lookups, combinational inside the cycle. There is no multi-cycle S-box pipeline.

Decomposition:
- Shared package aes_key_pkg holds:
  - the state enum {IDLE, EXPAND, DONE};
  - function xtime(byte);
  - function rot_word(word);
  - the 256-entry S-box constant table, shared with the encryption side.
- One sub-module, aes_sub_word: 32-bit input, 32-bit output, four parallel S-box lookups, purely combinational.
- The FSM, counters, Rcon register and word array stay in aes_key_expander.

Test Plan:
- Nk=4/Nr=10, key 2b7e151628aed2a6abf7158809cf4f3c, 1-cycle start:
  - done rises exactly 40 cycles later;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Nk=6/Nr=12, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done after 46 cycles;
  - w[51] (last word of k_sch) = 01002202.
- Nk=8/Nr=14, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done after 52 cycles;
  - w[59] = 706c631e, which exercises the j==4 SubWord path.
- Reset mid-operation: assert rst 20 cycles into an Nk=4 expansion.
  - Required: busy=0, done=0, k_sch all zero asynchronously.
  - A fresh start then yields the correct schedule after 40 cycles.
- Key hold and restart, Nk=4:
  - Pulse start during EXPAND and change key mid-run: the result still matches the originally sampled key.
  - In DONE, start with key 000102030405060708090a0b0c0d0e0f: done drops on that edge and returns after 40 cycles with round 10 = 13111d7fe3944a17f307a78b4d2b30c5.

Source files
------------

// File: rtl/aes_key_pkg.sv
// Shared AES key-schedule definitions: FSM states, Rcon step, RotWord and the
// forward S-box table (also used by the encryption datapath).
package aes_key_pkg;

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

    // Element 0 sits in the most significant byte, so SBOX[x] is S(x).
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups, purely combinational.
module aes_sub_word
    import aes_key_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    assign word_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]],
                     SBOX[word_i[15:8]],  SBOX[word_i[7:0]]};

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES key schedule: one 32-bit schedule word per clock for
// 128/192/256-bit keys; the word array itself is the k_sch output bus.
module aes_key_expander
    import aes_key_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [Nk*32-1:0]        key,
    output logic                    busy,
    output logic                    done,
    output logic [(Nr+1)*128-1:0]   k_sch
);

    localparam int NW = 4 * (Nr + 1);
    localparam int IW = $clog2(NW + 1);

    state_e                 state_q;
    logic [0:NW-1][31:0]    w_q;
    logic [IW-1:0]          i_q;
    logic [2:0]             j_q;
    logic [7:0]             rcon_q;
    logic                   busy_q;
    logic                   done_q;

    logic [31:0] w_prev, w_back, sub_in, sub_out, temp_d, w_new_d;

    assign w_prev = w_q[i_q - IW'(1)];
    assign w_back = w_q[i_q - IW'(Nk)];

    // One S-box bank serves both the rotated (j==0) and the plain (Nk==8, j==4) case.
    assign sub_in = (j_q == 3'd0) ? rot_word(w_prev) : w_prev;

    aes_sub_word u_sub_word (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    always_comb begin
        temp_d = w_prev;
        if (j_q == 3'd0)
            temp_d = sub_out ^ {rcon_q, 24'h000000};
        else if (Nk == 8 && j_q == 3'd4)
            temp_d = sub_out;
    end

    assign w_new_d = w_back ^ temp_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            rcon_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        for (int k = 0; k < Nk; k++)
                            w_q[k] <= key[(Nk-k)*32-1 -: 32];
                        i_q     <= IW'(Nk);
                        j_q     <= 3'd0;
                        rcon_q  <= 8'h01;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= EXPAND;
                    end
                end
                EXPAND: begin
                    w_q[i_q] <= w_new_d;
                    if (j_q == 3'd0)
                        rcon_q <= xtime(rcon_q);
                    i_q <= i_q + IW'(1);
                    j_q <= (j_q == 3'(Nk - 1)) ? 3'd0 : j_q + 3'd1;
                    if (i_q == IW'(NW - 1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign k_sch = w_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander with one instance per key size and a
// GF(2^8)-based reference key schedule.
module tb_aes_key_expander;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]     start_a;
    logic [2:0]     busy_a;
    logic [2:0]     done_a;
    logic [255:0]   kreg [3];
    logic [1407:0]  ks4;
    logic [1663:0]  ks6;
    logic [1919:0]  ks8;
    logic [1919:0]  ks_a [3];

    aes_key_expander #(.Nk(4), .Nr(10)) dut4 (
        .clk(clk), .rst(rst), .start(start_a[0]), .key(kreg[0][255:128]),
        .busy(busy_a[0]), .done(done_a[0]), .k_sch(ks4));
    aes_key_expander #(.Nk(6), .Nr(12)) dut6 (
        .clk(clk), .rst(rst), .start(start_a[1]), .key(kreg[1][255:64]),
        .busy(busy_a[1]), .done(done_a[1]), .k_sch(ks6));
    aes_key_expander #(.Nk(8), .Nr(14)) dut8 (
        .clk(clk), .rst(rst), .start(start_a[2]), .key(kreg[2]),
        .busy(busy_a[2]), .done(done_a[2]), .k_sch(ks8));

    assign ks_a[0] = {512'b0, ks4};
    assign ks_a[1] = {256'b0, ks6};
    assign ks_a[2] = ks8;

    typedef struct {
        logic [1919:0] ks;
        longint        cyc;
    } exp_t;

    exp_t       q [3][$];
    exp_t       mon_e;
    logic [2:0] dprev = '0;
    longint     cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] sb [256];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input int n);
        logic [7:0] p;
        p = 8'h01;
        for (int k = 1; k < n; k++) p = gmul(p, 8'h02);
        return p;
    endfunction

    // Returns the schedule bottom-aligned: last word in bits [31:0].
    function automatic logic [1919:0] model(input int nk, input logic [255:0] k);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [1919:0] r;
        int            nw;
        nw = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0)
                t = subw({t[23:0], t[31:24]}) ^ {rcon(i / nk), 24'h0};
            else if (nk == 8 && i % nk == 4)
                t = subw(t);
            w[i] = w[i-nk] ^ t;
        end
        r = '0;
        for (int i = 0; i < nw; i++) r[32*(nw-1-i) +: 32] = w[i];
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_ks(input int n, input logic [1919:0] act, input logic [1919:0] exp);
        int bad_k;
        int nw;
        bad_k = -1;
        nw = 4 * (4 + 2*n + 7);
        n_cmp++;
        for (int k = 0; k < 60; k++)
            if (act[32*k +: 32] !== exp[32*k +: 32]) bad_k = k;
        if (bad_k >= 0) begin
            n_bad++;
            $display("FAIL schedule inst%0d word %0d: got %h expected %h", n, nw - 1 - bad_k,
                     act[32*bad_k +: 32], exp[32*bad_k +: 32]);
        end
    endtask

    always @(negedge clk) begin
        for (int n = 0; n < 3; n++) begin
            if (done_a[n] && !dprev[n]) begin
                if (q[n].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_done inst%0d: got done=1 expected no pending expansion", n);
                end else begin
                    mon_e = q[n].pop_front();
                    check_ks(n, ks_a[n], mon_e.ks);
                    check($sformatf("latency inst%0d", n), 128'(cyc), 128'(mon_e.cyc));
                end
            end
            dprev[n] = done_a[n];
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input int n, input logic [255:0] k);
        exp_t e;
        int   nk;
        nk = 4 + 2*n;
        @(negedge clk);
        kreg[n]    = k;
        start_a[n] = 1'b1;
        e.ks  = model(nk, k);
        e.cyc = cyc + 1 + 4*(nk + 7) - nk;
        q[n].push_back(e);
        @(negedge clk);
        start_a[n] = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int k;
        k = 0;
        while (!done_a[n] && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (!done_a[n]) begin
            n_bad++;
            $display("FAIL done_timeout inst%0d: got done=0 expected done=1 within 200 cycles", n);
        end
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [255:0] KAT4 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KAT6 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KAT8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KSEQ = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

    initial begin
        rst     = 1'b1;
        start_a = '0;
        for (int n = 0; n < 3; n++) kreg[n] = '0;
        build_sbox();

        repeat (2) @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            check($sformatf("reset_busy inst%0d", n), 128'(busy_a[n]), 128'd0);
            check($sformatf("reset_done inst%0d", n), 128'(done_a[n]), 128'd0);
            check($sformatf("reset_ksch inst%0d", n), 128'(ks_a[n] != '0), 128'd0);
        end
        #1 rst = 1'b0;

        // Known-answer schedules for each key size
        issue(0, KAT4);
        check("busy_expand", 128'(busy_a[0]), 128'd1);
        wait_done(0);
        check("busy_after_done", 128'(busy_a[0]), 128'd0);
        check("kat4_round1", ks4[1279:1152], 128'ha0fafe1788542cb123a339392a6c7605);
        check("kat4_round10", ks4[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        issue(1, KAT6);
        wait_done(1);
        check("kat6_w51", 128'(ks6[31:0]), 128'h01002202);
        issue(2, KAT8);
        wait_done(2);
        check("kat8_w59", 128'(ks8[31:0]), 128'h706c631e);

        // Asynchronous reset in the middle of an expansion
        issue(0, KAT4);
        repeat (19) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midreset_busy", 128'(busy_a[0]), 128'd0);
        check("midreset_done", 128'(done_a[0]), 128'd0);
        check("midreset_ksch", 128'(ks4 != '0), 128'd0);
        q[0].delete();
        @(negedge clk);
        #1 rst = 1'b0;
        issue(0, KAT4);
        wait_done(0);
        check("postreset_round10", ks4[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        issue(1, KAT6);
        wait_done(1);
        issue(2, KAT8);
        wait_done(2);

        // start during EXPAND ignored, key changes after the start edge ignored
        issue(0, rand_key());
        repeat (5) @(negedge clk);
        start_a[0] = 1'b1;
        kreg[0]    = rand_key();
        @(negedge clk);
        start_a[0] = 1'b0;
        kreg[0]    = rand_key();
        check("ignored_start_busy", 128'(busy_a[0]), 128'd1);
        wait_done(0);

        // Restart straight from DONE
        issue(0, KSEQ);
        check("restart_done_drop", 128'(done_a[0]), 128'd0);
        check("restart_busy", 128'(busy_a[0]), 128'd1);
        wait_done(0);
        check("restart_round10", ks4[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Random keys on all three key sizes
        for (int r = 0; r < 6; r++) begin
            for (int n = 0; n < 3; n++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                issue(n, rand_key());
                wait_done(n);
            end
        end

        repeat (2) @(negedge clk);
        for (int n = 0; n < 3; n++)
            check($sformatf("pending_expect inst%0d", n), 128'(q[n].size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
